// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one async-FIFO write port among NREQ requesters.
// Optional per-requester beat and stall statistics are enabled with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] wdata_in,
  input  logic [NREQ-1:0]       last,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  input  logic                  fifo_wfull,
  output logic                  fifo_winc,
  output logic [DSIZE-1:0]      fifo_wdata
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    stat_beats,
  output logic [15:0]           stat_stall
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;

  logic [IW-1:0]   g;
  logic            req_g;
  logic            last_g;
  logic [DSIZE-1:0] data_g;
  logic [IW-1:0]   pick;
  logic            found;
  logic [IW:0]     idx;
  logic [IW-1:0]   ptr_next;
  logic            burst_end;

  // Decode the held one-hot grant into the granted requester's signals.
  // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    g      = '0;
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g      = IW'(i);
        req_g  = req[i];
        last_g = last[i];
        data_g = wdata_in[i*DSIZE +: DSIZE];
      end
    end
  end

  // First requesting port scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // gnt is non-zero only in BURST; reset suppresses any write in its own cycle.
  assign fifo_winc  = req_g & ~fifo_wfull & ~rst;
  assign ack        = gnt & {NREQ{fifo_winc}};
  assign fifo_wdata = data_g;

  assign ptr_next  = (g == IW'(NREQ-1)) ? '0 : g + 1'b1;
  assign burst_end = !req_g || (fifo_winc && (last_g || cnt == CW'(MAX_BURST-1)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= NREQ'(1) << pick;
            state <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= ptr_next;
            state <= IDLE;
          end else if (fifo_winc) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && stat_beats[i*16 +: 16] != 16'hFFFF)
          stat_beats[i*16 +: 16] <= stat_beats[i*16 +: 16] + 16'd1;
      end
      if (state == BURST && req_g && fifo_wfull && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] wdata_in;
  logic [NREQ-1:0]       last;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_wfull;
  logic                  fifo_winc;
  logic [DSIZE-1:0]      fifo_wdata;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]    stat_beats;
  logic [15:0]           stat_stall;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata_in   (wdata_in),
    .last       (last),
    .ack        (ack),
    .gnt        (gnt),
    .fifo_wfull (fifo_wfull),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (-1 = nobody), beats written so far, next-priority port.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  logic [DSIZE-1:0] wlog[$];
  int               gorder[$];
  logic [NREQ-1:0]  prev_gnt = '0;
  logic [NREQ-1:0]  obs_ack  = '0;
  int               sc[NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_end();
    m_ptr   = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % NREQ])
          m_owner = (m_ptr + k) % NREQ;
      end
    end else if (!req[m_owner]) begin
      model_end();
    end else if (!fifo_wfull) begin
      m_beats++;
      if (last[m_owner] || m_beats == MAX_BURST)
        model_end();
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [NREQ-1:0]  e_gnt;
    logic             e_winc;
    logic [DSIZE-1:0] e_data;
    #2;
    e_gnt  = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
    e_winc = (m_owner >= 0) && req[m_owner] && !fifo_wfull && !rst;
    e_data = (m_owner < 0) ? '0 : wdata_in[m_owner*DSIZE +: DSIZE];
    check("gnt",   32'(gnt),        32'(e_gnt));
    check("winc",  32'(fifo_winc),  32'(e_winc));
    check("ack",   32'(ack),        e_winc ? 32'(e_gnt) : 32'd0);
    check("wdata", 32'(fifo_wdata), 32'(e_data));
    if (fifo_winc) wlog.push_back(fifo_wdata);
    if (gnt != 0 && prev_gnt == 0)
      for (int k = 0; k < NREQ; k++) if (gnt[k]) gorder.push_back(k);
    prev_gnt = gnt;
    obs_ack  = ack;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; last = '0; wdata_in = '0; fifo_wfull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",   32'(gnt),        32'd0);
    check("rst_winc",  32'(fifo_winc),  32'd0);
    check("rst_ack",   32'(ack),        32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
    rst = 1'b0;

    // 1: single requester, three-beat burst.
    req = 4'b0010; wdata_in[8 +: 8] = 8'h11; wlog.delete();
    step();
    check("s1_gnt", 32'(gnt), 32'h2);
    step();
    wdata_in[8 +: 8] = 8'h22; step();
    wdata_in[8 +: 8] = 8'h33; last = 4'b0010; step();
    req = '0; last = '0;
    check("s1_end", 32'(gnt), 32'h0);
    step();
    check("s1_n", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      check("s1_d0", 32'(wlog[0]), 32'h11);
      check("s1_d1", 32'(wlog[1]), 32'h22);
      check("s1_d2", 32'(wlog[2]), 32'h33);
    end

    // 2: round-robin with all four requesting, two-beat bursts.
    do_reset();
    gorder.delete();
    for (int i = 0; i < NREQ; i++) sc[i] = 0;
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        last[i] = (sc[i] % 2 == 1);
        wdata_in[i*8 +: 8] = 8'($urandom);
      end
      step();
      for (int i = 0; i < NREQ; i++) if (obs_ack[i]) sc[i]++;
    end
    check("s2_ngrants", 32'(gorder.size() >= 5), 32'd1);
    if (gorder.size() >= 5) begin
      check("s2_g0", 32'(gorder[0]), 32'd0);
      check("s2_g1", 32'(gorder[1]), 32'd1);
      check("s2_g2", 32'(gorder[2]), 32'd2);
      check("s2_g3", 32'(gorder[3]), 32'd3);
      check("s2_g4", 32'(gorder[4]), 32'd0);
    end
    req = '0; last = '0;

    // 3: burst length cap.
    do_reset();
    req = 4'b0100; wlog.delete();
    repeat (9) step();
    check("s3_beats", 32'(wlog.size()), 32'(MAX_BURST));
    check("s3_end",   32'(gnt), 32'h0);
    step();
    check("s3_regrant", 32'(gnt), 32'h4);
    req = '0;

    // 4: full stall after beat 2.
    do_reset();
    req = 4'b0001; wlog.delete(); wdata_in[7:0] = 8'hA1;
    step(); step();
    wdata_in[7:0] = 8'hA2; step();
    wdata_in[7:0] = 8'hA3; fifo_wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("s4_winc", 32'(fifo_winc), 32'd0);
      check("s4_ack",  32'(ack),       32'd0);
      check("s4_gnt",  32'(gnt),       32'h1);
      step();
    end
    fifo_wfull = 1'b0; step();
    wdata_in[7:0] = 8'hA4; last = 4'b0001; step();
    req = '0; last = '0; step();
    check("s4_n", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < wlog.size() && i < 4; i++)
      check("s4_data", 32'(wlog[i]), 32'hA1 + 32'(i));
`ifdef FIFO_WR_ARB_STATS_EN
    check("s6_stall", 32'(stat_stall),       32'd5);
    check("s6_beats", 32'(stat_beats[15:0]), 32'd4);
`endif

    // 5: abandon, then reset mid-burst.
    do_reset();
    req = 4'b0100;
    step(); step();
    req = '0; step();
    check("s5_abandon", 32'(gnt), 32'h0);
    req = 4'b1111; last = 4'b1111;
    step();
    check("s5_ptr", 32'(gnt), 32'h8);
    rst = 1'b1;
    #1;
    check("s5_rst_winc", 32'(fifo_winc), 32'd0);
    step();
    rst = 1'b0;
    check("s5_rst_gnt", 32'(gnt), 32'h0);
    step();
    check("s5_rst_ptr", 32'(gnt), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    req = '0; last = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (obs_ack[i]) begin
            req[i]             = ($urandom_range(0, 4) != 0);
            wdata_in[i*8 +: 8] = 8'($urandom);
            last[i]            = ($urandom_range(0, 3) == 0);
          end else if ($urandom_range(0, 31) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i]             = 1'b1;
          wdata_in[i*8 +: 8] = 8'($urandom);
          last[i]            = ($urandom_range(0, 3) == 0);
        end
      end
      fifo_wfull = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

`ifdef FIFO_WR_ARB_STATS_EN
    // Saturation: a lone requester streams capped bursts well past 65535 beats.
    do_reset();
    req = 4'b0001; last = '0; fifo_wfull = 1'b0;
    repeat (74000) @(posedge clk);
    #1;
    check("s6_sat", 32'(stat_beats[15:0]), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
